cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Write-back scheduler between the two result producers (ALU/reservation station and load-store buffer) and the reorder buffer.
- Each producer pushes results into a private queue through a valid/ready handshake.
- The block grants one queued result per cycle onto a single registered common data bus (CDB). The ROB and the dependency-forwarding logic consume this bus.
- A flush from the ROB discards all queued and in-flight results.

Parameters:
- ROB_W, 4, width of a ROB index.
- Q_DEPTH, 2, entries per producer queue (power of two, ≥2).

Ports:
- clk_in  input  1  clock, all state on rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- rdy_in  input  1  global enable; low = full hold.
- flush_in  input  1  ROB misprediction clear (synchronous).
- alu_valid  input  1  ALU result offered.
- alu_ready  output  1  ALU queue can accept.
- alu_rob_id  input  ROB_W  destination ROB entry.
- alu_value  input  32  result value.
- alu_has_tgt  input  1  result carries a jalr target.
- alu_tgt  input  32  jalr target pc.
- lsb_valid  input  1  LSB result offered.
- lsb_ready  output  1  LSB queue can accept.
- lsb_rob_id  input  ROB_W  destination ROB entry.
- lsb_value  input  32  load/store result.
- cdb_valid  output  1  bus carries a result this cycle.
- cdb_rob_id  output  ROB_W  ROB entry being written.
- cdb_value  output  32  value.
- cdb_has_tgt  output  1  jalr target present (always 0 for LSB grants).
- cdb_tgt  output  32  jalr target.
- cdb_src  output  1  0 = ALU, 1 = LSB.

Behaviour:
- Reset (rst_n_in low, async):
  - Both queues emptied; head, tail and count = 0.
  - All cdb_* outputs = 0; alu_ready and lsb_ready = 0 while in reset.
  - last_grant = LSB, so the first contested grant goes to ALU.
- Ready:
  - x_ready = rdy_in && !flush_in && count_x < Q_DEPTH, using the registered count.
  - A full queue is not ready even if it dequeues in the same cycle.
- Enqueue: on a clock edge with rdy_in && x_valid && x_ready, write to tail, tail++ (wraps modulo Q_DEPTH), count++.
- Arbitration (combinational on queue heads, registered result):
  - Only ALU nonempty → grant ALU. Only LSB nonempty → grant LSB.
  - Both nonempty → grant the source opposite last_grant; update last_grant.
  - The granted head is dequeued and copied into the cdb_* registers at the same edge.
  - cdb_valid = 1 for exactly one cycle per result.
  - No grant → cdb_valid = 0; the other cdb fields hold their old values.
- Latency: a result accepted at edge E0 into an empty, uncontested queue appears on the CDB in the cycle after edge E1. There is no bypass path.
- Simultaneous enqueue and dequeue on the same queue: count unchanged, FIFO order preserved.
- Both producers may enqueue in the same cycle.
- rdy_in low: no enqueue, no dequeue, all registers hold, including cdb_valid.
- flush_in high with rdy_in high (takes effect at the edge):
  - Both queues cleared and cdb_valid = 0 next cycle.
  - Handshakes offered in the flush cycle are dropped.
  - last_grant returns to LSB.
  - A flush with rdy_in low is ignored.
- Reset mid-operation: immediate clear regardless of clk_in and rdy_in.
- Ordering: per-source FIFO order is guaranteed; there is no ordering guarantee across sources.

Optional Feature:
- Macro: CDB_LSB_PRIO_EN.
- Defined: when both queues are nonempty, LSB is always granted (load results are on the critical dependency path) and last_grant is not used.
  - Starvation guard: after 3 consecutive contested LSB grants, the next contested grant goes to ALU; the counter resets on any ALU grant or on flush.
- Undefined: pure round-robin as described in Behaviour.

Test Plan:
- Single ALU push (rob_id=3, value=0x1234) into idle block → cdb_valid=1 one cycle later for exactly one cycle; rob_id=3, value=0x1234, src=0.
- ALU (id 1) and LSB (id 2) push the same cycle, both repeating ×4 → CDB alternates 1,2,1,2… starting with ALU; no entry lost or duplicated.
- Hold alu_valid with the CDB contested until the ALU queue holds Q_DEPTH=2 entries → alu_ready=0; then drain → order preserved and ready reasserts one cycle after count drops.
- Queue 2 entries on each side, then pulse flush_in → next cycle cdb_valid=0, both ready=1, and no stale id ever appears afterwards.
- rdy_in low for 3 cycles with the CDB showing id 5 → cdb_valid/id stay 5, no dequeue; resume gives the next entry. Async rst_n_in low mid-cycle → outputs clear immediately.
- With CDB_LSB_PRIO_EN and both sources saturated → grant pattern LSB,LSB,LSB,ALU repeating.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Write-back scheduler: two producer FIFOs arbitrated onto one registered common data bus.
// Optional macro CDB_LSB_PRIO_EN: LSB wins contested grants, with an anti-starvation turn for ALU.
module cdb_arbiter #(
    parameter int ROB_W   = 4,
    parameter int Q_DEPTH = 2
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [ROB_W-1:0] alu_rob_id,
    input  logic [31:0]      alu_value,
    input  logic             alu_has_tgt,
    input  logic [31:0]      alu_tgt,
    input  logic             lsb_valid,
    output logic             lsb_ready,
    input  logic [ROB_W-1:0] lsb_rob_id,
    input  logic [31:0]      lsb_value,
    output logic             cdb_valid,
    output logic [ROB_W-1:0] cdb_rob_id,
    output logic [31:0]      cdb_value,
    output logic             cdb_has_tgt,
    output logic [31:0]      cdb_tgt,
    output logic             cdb_src
);
    localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int CNT_W = $clog2(Q_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(Q_DEPTH);

    typedef enum logic [1:0] {GNT_NONE, GNT_ALU, GNT_LSB} grant_e;

    logic [ROB_W-1:0] alu_id_mem  [Q_DEPTH];
    logic [31:0]      alu_val_mem [Q_DEPTH];
    logic             alu_ht_mem  [Q_DEPTH];
    logic [31:0]      alu_tgt_mem [Q_DEPTH];
    logic [ROB_W-1:0] lsb_id_mem  [Q_DEPTH];
    logic [31:0]      lsb_val_mem [Q_DEPTH];

    logic [PTR_W-1:0] alu_head_q, alu_head_d, alu_tail_q, alu_tail_d;
    logic [PTR_W-1:0] lsb_head_q, lsb_head_d, lsb_tail_q, lsb_tail_d;
    logic [CNT_W-1:0] alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;

    logic             cdb_valid_q, cdb_valid_d;
    logic [ROB_W-1:0] cdb_rob_id_q, cdb_rob_id_d;
    logic [31:0]      cdb_value_q, cdb_value_d;
    logic             cdb_has_tgt_q, cdb_has_tgt_d;
    logic [31:0]      cdb_tgt_q, cdb_tgt_d;
    logic             cdb_src_q, cdb_src_d;

`ifdef CDB_LSB_PRIO_EN
    logic [1:0]       lsb_streak_q, lsb_streak_d;
`else
    logic             last_lsb_q, last_lsb_d;
`endif

    logic   alu_push, lsb_push, alu_pop, lsb_pop, alu_ne, lsb_ne, contested;
    grant_e grant;

    always_comb begin
        alu_ready = rst_n_in && rdy_in && !flush_in && (alu_cnt_q < CNT_MAX);
        lsb_ready = rst_n_in && rdy_in && !flush_in && (lsb_cnt_q < CNT_MAX);
        alu_push  = alu_valid && alu_ready;
        lsb_push  = lsb_valid && lsb_ready;
        alu_ne    = (alu_cnt_q != '0);
        lsb_ne    = (lsb_cnt_q != '0);
        contested = alu_ne && lsb_ne;

        grant = GNT_NONE;
        if (rdy_in && !flush_in) begin
            if (contested) begin
`ifdef CDB_LSB_PRIO_EN
                grant = (lsb_streak_q == 2'd3) ? GNT_ALU : GNT_LSB;
`else
                grant = last_lsb_q ? GNT_ALU : GNT_LSB;
`endif
            end else if (alu_ne) begin
                grant = GNT_ALU;
            end else if (lsb_ne) begin
                grant = GNT_LSB;
            end
        end
        alu_pop = (grant == GNT_ALU);
        lsb_pop = (grant == GNT_LSB);

        alu_head_d    = alu_head_q;
        alu_tail_d    = alu_tail_q;
        alu_cnt_d     = alu_cnt_q;
        lsb_head_d    = lsb_head_q;
        lsb_tail_d    = lsb_tail_q;
        lsb_cnt_d     = lsb_cnt_q;
        cdb_valid_d   = cdb_valid_q;
        cdb_rob_id_d  = cdb_rob_id_q;
        cdb_value_d   = cdb_value_q;
        cdb_has_tgt_d = cdb_has_tgt_q;
        cdb_tgt_d     = cdb_tgt_q;
        cdb_src_d     = cdb_src_q;
`ifdef CDB_LSB_PRIO_EN
        lsb_streak_d  = lsb_streak_q;
`else
        last_lsb_d    = last_lsb_q;
`endif

        if (rdy_in && flush_in) begin
            alu_head_d  = '0;
            alu_tail_d  = '0;
            alu_cnt_d   = '0;
            lsb_head_d  = '0;
            lsb_tail_d  = '0;
            lsb_cnt_d   = '0;
            cdb_valid_d = 1'b0;
`ifdef CDB_LSB_PRIO_EN
            lsb_streak_d = 2'd0;
`else
            last_lsb_d   = 1'b1;
`endif
        end else if (rdy_in) begin
            alu_tail_d  = alu_tail_q + PTR_W'(alu_push);
            alu_head_d  = alu_head_q + PTR_W'(alu_pop);
            alu_cnt_d   = alu_cnt_q + CNT_W'(alu_push) - CNT_W'(alu_pop);
            lsb_tail_d  = lsb_tail_q + PTR_W'(lsb_push);
            lsb_head_d  = lsb_head_q + PTR_W'(lsb_pop);
            lsb_cnt_d   = lsb_cnt_q + CNT_W'(lsb_push) - CNT_W'(lsb_pop);
            cdb_valid_d = (grant != GNT_NONE);
            if (alu_pop) begin
                cdb_rob_id_d  = alu_id_mem[alu_head_q];
                cdb_value_d   = alu_val_mem[alu_head_q];
                cdb_has_tgt_d = alu_ht_mem[alu_head_q];
                cdb_tgt_d     = alu_tgt_mem[alu_head_q];
                cdb_src_d     = 1'b0;
            end else if (lsb_pop) begin
                cdb_rob_id_d  = lsb_id_mem[lsb_head_q];
                cdb_value_d   = lsb_val_mem[lsb_head_q];
                cdb_has_tgt_d = 1'b0;
                cdb_tgt_d     = 32'd0;
                cdb_src_d     = 1'b1;
            end
`ifdef CDB_LSB_PRIO_EN
            // Only contested LSB wins count toward the ALU starvation turn.
            if (alu_pop) begin
                lsb_streak_d = 2'd0;
            end else if (lsb_pop && contested) begin
                lsb_streak_d = lsb_streak_q + 2'd1;
            end
`else
            if (contested) begin
                last_lsb_d = lsb_pop;
            end
`endif
        end
    end

    // Queue payload storage carries no reset; the counters decide what is live.
    always_ff @(posedge clk_in) begin
        if (alu_push) begin
            alu_id_mem[alu_tail_q]  <= alu_rob_id;
            alu_val_mem[alu_tail_q] <= alu_value;
            alu_ht_mem[alu_tail_q]  <= alu_has_tgt;
            alu_tgt_mem[alu_tail_q] <= alu_tgt;
        end
        if (lsb_push) begin
            lsb_id_mem[lsb_tail_q]  <= lsb_rob_id;
            lsb_val_mem[lsb_tail_q] <= lsb_value;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            alu_head_q    <= '0;
            alu_tail_q    <= '0;
            alu_cnt_q     <= '0;
            lsb_head_q    <= '0;
            lsb_tail_q    <= '0;
            lsb_cnt_q     <= '0;
            cdb_valid_q   <= 1'b0;
            cdb_rob_id_q  <= '0;
            cdb_value_q   <= '0;
            cdb_has_tgt_q <= 1'b0;
            cdb_tgt_q     <= '0;
            cdb_src_q     <= 1'b0;
`ifdef CDB_LSB_PRIO_EN
            lsb_streak_q  <= 2'd0;
`else
            last_lsb_q    <= 1'b1;
`endif
        end else begin
            alu_head_q    <= alu_head_d;
            alu_tail_q    <= alu_tail_d;
            alu_cnt_q     <= alu_cnt_d;
            lsb_head_q    <= lsb_head_d;
            lsb_tail_q    <= lsb_tail_d;
            lsb_cnt_q     <= lsb_cnt_d;
            cdb_valid_q   <= cdb_valid_d;
            cdb_rob_id_q  <= cdb_rob_id_d;
            cdb_value_q   <= cdb_value_d;
            cdb_has_tgt_q <= cdb_has_tgt_d;
            cdb_tgt_q     <= cdb_tgt_d;
            cdb_src_q     <= cdb_src_d;
`ifdef CDB_LSB_PRIO_EN
            lsb_streak_q  <= lsb_streak_d;
`else
            last_lsb_q    <= last_lsb_d;
`endif
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign cdb_rob_id  = cdb_rob_id_q;
    assign cdb_value   = cdb_value_q;
    assign cdb_has_tgt = cdb_has_tgt_q;
    assign cdb_tgt     = cdb_tgt_q;
    assign cdb_src     = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed steps then random traffic, compared against a queue-based model.
module tb_cdb_arbiter;
    localparam int ROB_W = 4;
    localparam int QD    = 2;

    logic             clk_in = 1'b0;
    logic             rst_n_in = 1'b0;
    logic             rdy_in = 1'b0, flush_in = 1'b0;
    logic             alu_valid = 1'b0, alu_ready;
    logic [ROB_W-1:0] alu_rob_id = '0;
    logic [31:0]      alu_value = '0, alu_tgt = '0;
    logic             alu_has_tgt = 1'b0;
    logic             lsb_valid = 1'b0, lsb_ready;
    logic [ROB_W-1:0] lsb_rob_id = '0;
    logic [31:0]      lsb_value = '0;
    logic             cdb_valid, cdb_has_tgt, cdb_src;
    logic [ROB_W-1:0] cdb_rob_id;
    logic [31:0]      cdb_value, cdb_tgt;

    cdb_arbiter #(.ROB_W(ROB_W), .Q_DEPTH(QD)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rob_id(alu_rob_id),
        .alu_value(alu_value), .alu_has_tgt(alu_has_tgt), .alu_tgt(alu_tgt),
        .lsb_valid(lsb_valid), .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id),
        .lsb_value(lsb_value), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
        .cdb_value(cdb_value), .cdb_has_tgt(cdb_has_tgt), .cdb_tgt(cdb_tgt),
        .cdb_src(cdb_src)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [ROB_W-1:0] id;
        logic [31:0]      val;
        logic             ht;
        logic [31:0]      tgt;
    } ent_t;

    ent_t aq[$];
    ent_t lq[$];
    logic             m_valid = 1'b0, m_ht = 1'b0, m_src = 1'b0;
    logic [ROB_W-1:0] m_id = '0;
    logic [31:0]      m_val = '0, m_tgt = '0;
    bit               m_last_lsb = 1'b1;
    int               m_streak = 0;
    int               total = 0;
    int               bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        aq.delete();
        lq.delete();
        m_valid = 1'b0; m_id = '0; m_val = '0; m_ht = 1'b0; m_tgt = '0; m_src = 1'b0;
        m_last_lsb = 1'b1;
        m_streak = 0;
    endtask

    task automatic chk_cdb();
        chk("cdb_valid", 32'(cdb_valid), 32'(m_valid));
        chk("cdb_rob_id", 32'(cdb_rob_id), 32'(m_id));
        chk("cdb_value", cdb_value, m_val);
        chk("cdb_has_tgt", 32'(cdb_has_tgt), 32'(m_ht));
        chk("cdb_tgt", cdb_tgt, m_tgt);
        chk("cdb_src", 32'(cdb_src), 32'(m_src));
    endtask

    // One clock cycle: drive at the negedge, check ready, predict, check bus after the edge.
    task automatic cyc(input bit rdy, input bit fl,
                       input bit av, input logic [ROB_W-1:0] aid, input logic [31:0] aval,
                       input bit aht, input logic [31:0] atgt,
                       input bit lv, input logic [ROB_W-1:0] lid, input logic [31:0] lval);
        bit   e_ar, e_lr;
        int   g;
        ent_t e;
        rdy_in = rdy; flush_in = fl;
        alu_valid = av; alu_rob_id = aid; alu_value = aval; alu_has_tgt = aht; alu_tgt = atgt;
        lsb_valid = lv; lsb_rob_id = lid; lsb_value = lval;
        #1;
        e_ar = rdy && !fl && (aq.size() < QD);
        e_lr = rdy && !fl && (lq.size() < QD);
        chk("alu_ready", 32'(alu_ready), 32'(e_ar));
        chk("lsb_ready", 32'(lsb_ready), 32'(e_lr));
        if (rdy && fl) begin
            aq.delete();
            lq.delete();
            m_valid = 1'b0;
            m_last_lsb = 1'b1;
            m_streak = 0;
        end else if (rdy) begin
            g = 0;
            if (aq.size() > 0 && lq.size() > 0) begin
`ifdef CDB_LSB_PRIO_EN
                g = (m_streak == 3) ? 1 : 2;
                m_streak = (g == 1) ? 0 : m_streak + 1;
`else
                g = m_last_lsb ? 1 : 2;
                m_last_lsb = (g == 2);
`endif
            end else if (aq.size() > 0) begin
                g = 1;
                m_streak = 0;
            end else if (lq.size() > 0) begin
                g = 2;
            end
            if (g == 1) begin
                e = aq.pop_front();
                m_id = e.id; m_val = e.val; m_ht = e.ht; m_tgt = e.tgt; m_src = 1'b0;
            end else if (g == 2) begin
                e = lq.pop_front();
                m_id = e.id; m_val = e.val; m_ht = 1'b0; m_tgt = 32'd0; m_src = 1'b1;
            end
            m_valid = (g != 0);
            if (av && e_ar) aq.push_back('{aid, aval, aht, atgt});
            if (lv && e_lr) lq.push_back('{lid, lval, 1'b0, 32'd0});
        end
        @(posedge clk_in);
        #1;
        chk_cdb();
        if (cdb_valid)
            $display("cdb grant t=%0t src=%0d id=%0h value=%08h has_tgt=%0d tgt=%08h",
                     $time, cdb_src, cdb_rob_id, cdb_value, cdb_has_tgt, cdb_tgt);
        @(negedge clk_in);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, '0, 32'd0, 0, 32'd0, 0, '0, 32'd0);
    endtask

    initial begin
        // Reset state
        model_reset();
        #3;
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_lsb_ready", 32'(lsb_ready), 32'd0);
        chk_cdb();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        idle(1);

        // Single ALU push: id 3, value 0x1234, then one-cycle pulse
        cyc(1, 0, 1, 4'd3, 32'h1234, 0, 32'd0, 0, '0, 32'd0);
        idle(3);

        // Both producers push together, four times: ALU first, then alternating
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 1, 4'd1, 32'hA000 + i, 1, 32'h100 + i, 1, 4'd2, 32'hB000 + i);
        idle(8);

        // Contested fill until the ALU queue saturates, then drain
        for (int i = 0; i < 6; i++)
            cyc(1, 0, 1, 4'(i + 8), 32'hC000 + i, 0, 32'd0, 1, 4'(i), 32'hD000 + i);
        idle(12);

        // Fill both queues, then flush with handshakes offered (dropped)
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 1, 4'(i + 10), 32'hE000 + i, 0, 32'd0, 1, 4'(i + 12), 32'hF000 + i);
        cyc(1, 1, 1, 4'd7, 32'h7777, 1, 32'h7, 1, 4'd9, 32'h9999);
        idle(4);

        // Hold with id 5 on the bus, then resume for id 6
        cyc(1, 0, 1, 4'd5, 32'h5555, 0, 32'd0, 0, '0, 32'd0);
        cyc(1, 0, 1, 4'd6, 32'h6666, 1, 32'h60, 0, '0, 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0, 32'd0, 0, 32'd0, 0, '0, 32'd0);
        idle(3);

        // Flush while on hold must be ignored
        cyc(1, 0, 1, 4'd4, 32'h4444, 0, 32'd0, 1, 4'd8, 32'h8888);
        cyc(0, 1, 0, '0, 32'd0, 0, 32'd0, 0, '0, 32'd0);
        idle(4);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 7) != 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 1) == 1, 4'($urandom), $urandom, $urandom_range(0, 1) == 1, $urandom,
                $urandom_range(0, 2) != 0, 4'($urandom), $urandom);

        // Asynchronous reset in the middle of a cycle with traffic pending
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 1, 4'(i), 32'h1000 + i, 0, 32'd0, 1, 4'(i + 4), 32'h2000 + i);
        #2;
        rst_n_in = 1'b0;
        #1;
        model_reset();
        chk("arst_alu_ready", 32'(alu_ready), 32'd0);
        chk("arst_lsb_ready", 32'(lsb_ready), 32'd0);
        chk_cdb();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
